// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and defaults for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_RESET_PC = 0;
    localparam int DEFAULT_PC_STEP  = 1;
    localparam int BUF_DEPTH        = 2;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of {pc, inst} pairs; flush beats push and pop
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(BUF_DEPTH),
    parameter int CNT_W  = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_inst,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_inst
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
    logic [DATA_W-1:0] inst_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              pop_ok;
    logic              push_ok;

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL_CNT) || pop_ok);

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch initiator feeding decode; FETCH_PERF_EN adds perf counters
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int               CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              push;
    logic              pop;
    logic              pop_req;
    logic              flush;
    logic              full;
    logic [CNT_W-1:0]  buf_count;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_inst;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_inst;

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);
    assign out_valid = (buf_count != '0);
    assign full      = (buf_count == FULL_CNT);
    assign pop_req   = out_valid && out_ready;
    // A redirect voids any pop that decode tried in the same cycle.
    assign pop       = pop_req && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else begin
                    if (!full || pop_req) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_STEP;
                    end
                    if (halt_req) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_pc   (pc_q),
        .push_inst (imem_data),
        .pop       (pop),
        .count     (buf_count),
        .head_pc   (head_pc),
        .head_inst (head_inst)
    );

    // Remember the last presented pair so out_* stay put while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc   <= '0;
            hold_inst <= '0;
        end else if (out_valid) begin
            hold_pc   <= head_pc;
            hold_inst <= head_inst;
        end
    end

    assign out_pc   = out_valid ? head_pc   : hold_pc;
    assign out_inst = out_valid ? head_inst : hold_inst;

`ifdef FETCH_PERF_EN
    logic stall;

    assign stall = (state_q == FETCH) && full && !pop_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
